mux_scan_capture: RTL and testbench

Sequencer and deserializer that pairs with the 16:1 bit-select mux.
- Drives the mux `sel` input through channels 0..IN_LENGTH-1.
- After a programmable settle time, samples the mux's single-bit output and assembles the bits into an IN_LENGTH-bit word.
- Delivers each word downstream over a valid/ready handshake.
- Supports a one-shot mode and a continuous scanning mode.

---
 rtl/mux_scan_capture.sv | 161 ++++++++++++++++
 tb/tb_mux_scan_capture.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_capture.sv
// -----------------------------------------------------------------------------
// mux_scan_capture
//
// Purpose:
//   Sequencer/deserializer for an N:1 bit-select mux. It walks the mux select
//   through channels 0..IN_LENGTH-1. After each select change it waits
//   SETTLE_CYCLES idle cycles and then samples the mux output on one cycle.
//   The sampled bits are assembled into an IN_LENGTH-bit word, and that word
//   is handed downstream over a valid/ready handshake. Scans are either
//   one-shot or continuous; `stop` ends continuous mode after the current word.
//
// Ports:
//   clk         in   rising-edge clock
//   rstn        in   synchronous active-low reset
//   start       in   begin a scan (honoured only when idle)
//   cont        in   captured with start: 1 = continuous scanning
//   stop        in   clear continuous mode (current word still completes)
//   sel         out  channel select driven to the mux
//   mux_out     in   selected bit returned by the mux
//   data_out    out  captured word, bit k = channel k
//   data_valid  out  data_out holds a complete word
//   data_ready  in   downstream accepts the word
//   busy        out  high whenever not idle
// -----------------------------------------------------------------------------
module mux_scan_capture #(
    parameter int IN_LENGTH     = 16,
    parameter int SEL_LENGTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  stop,
    output logic [SEL_LENGTH-1:0] sel,
    input  logic                  mux_out,
    output logic [IN_LENGTH-1:0]  data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [SEL_LENGTH-1:0] SEL_LAST = SEL_LENGTH'(IN_LENGTH - 1);

    // Last value of the settle counter before moving to SAMPLE. With no
    // settle time the SETTLE state is never entered, so the value is unused.
    localparam logic [3:0] SETTLE_LAST =
        4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

    // State entered right after every sel update (scan start, channel step,
    // continuous restart). A zero settle time skips SETTLE entirely.
    localparam state_t FIRST_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t                state_reg;
    logic [SEL_LENGTH-1:0] sel_reg;
    logic [3:0]            settle_cnt_reg;
    logic [IN_LENGTH-1:0]  word_reg;
    logic [IN_LENGTH-1:0]  word_next;
    logic [IN_LENGTH-1:0]  data_out_reg;
    logic                  data_valid_reg;
    logic                  busy_reg;
    logic                  cont_reg;

    // Word as it will look once the current mux bit is written into
    // position sel. This lets the last channel go straight into data_out
    // on the same edge that samples it.
    genvar gi;
    generate
        for (gi = 0; gi < IN_LENGTH; gi++) begin : g_word
            assign word_next[gi] = (sel_reg == SEL_LENGTH'(gi)) ? mux_out
                                                                : word_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            sel_reg        <= '0;
            settle_cnt_reg <= '0;
            word_reg       <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            cont_reg       <= 1'b0;
        end else begin
            // stop drops continuous mode from any state; the IDLE start
            // branch below overrides this when a new scan is launched.
            if (stop) begin
                cont_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg      <= FIRST_STATE;
                        sel_reg        <= '0;
                        settle_cnt_reg <= '0;
                        cont_reg       <= cont & ~stop;
                        busy_reg       <= 1'b1;
                    end
                end

                SETTLE: begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        state_reg      <= SAMPLE;
                        settle_cnt_reg <= '0;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 4'd1;
                    end
                end

                SAMPLE: begin
                    word_reg <= word_next;
                    if (sel_reg == SEL_LAST) begin
                        state_reg      <= HOLD;
                        data_out_reg   <= word_next;
                        data_valid_reg <= 1'b1;
                    end else begin
                        sel_reg        <= sel_reg + 1'b1;
                        settle_cnt_reg <= '0;
                        state_reg      <= FIRST_STATE;
                    end
                end

                HOLD: begin
                    // data_valid is always high here, so data_ready alone
                    // completes the handshake.
                    if (data_ready) begin
                        data_valid_reg <= 1'b0;
                        if (cont_reg && !stop) begin
                            state_reg      <= FIRST_STATE;
                            sel_reg        <= '0;
                            settle_cnt_reg <= '0;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = sel_reg;
    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_mux_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_capture
//
// Purpose:
//   Self-checking bench for mux_scan_capture. It builds three instances:
//     0: defaults (16 channels, settle 1)
//     1: 16 channels, settle 0
//     2: 12 channels, 4-bit select, settle 2
//   Each instance has its own behavioural mux model. The expected select
//   sequence, valid latency and captured word are derived from the channel
//   count and settle time alone.
// -----------------------------------------------------------------------------
module tb_mux_scan_capture;

    localparam int N_TAB [3] = '{16, 16, 12};
    localparam int S_TAB [3] = '{1, 0, 2};

    logic        clk = 1'b0;
    logic        rstn;
    logic        cont;
    logic        stop;
    logic        ready;
    logic [2:0]  start_v;
    logic [15:0] in_w [3];

    logic [3:0]  sel_a, sel_b, sel_c;
    logic        mux_a, mux_b, mux_c;
    logic [15:0] dout_a, dout_b;
    logic [11:0] dout_c;
    logic        dv_a, dv_b, dv_c;
    logic        busy_a, busy_b, busy_c;

    logic [3:0]  sel_o  [3];
    logic [15:0] dout   [3];
    logic        dv     [3];
    logic        busy_o [3];

    logic        sel_c_high;
    int          total;
    int          bad;

    always #5 clk = ~clk;

    // Mux models: return bit [sel] of the word presented on each instance.
    assign mux_a = in_w[0][sel_a];
    assign mux_b = in_w[1][sel_b];
    assign mux_c = (sel_c < 4'd12) ? in_w[2][sel_c] : 1'b0;

    // Records any attempt by the 12-channel instance to select channels 12..15.
    always @(posedge clk) begin
        if (sel_c > 4'd11) sel_c_high <= 1'b1;
    end

    always_comb begin
        sel_o[0]  = sel_a;  sel_o[1]  = sel_b;  sel_o[2]  = sel_c;
        dout[0]   = dout_a; dout[1]   = dout_b; dout[2]   = {4'b0, dout_c};
        dv[0]     = dv_a;   dv[1]     = dv_b;   dv[2]     = dv_c;
        busy_o[0] = busy_a; busy_o[1] = busy_b; busy_o[2] = busy_c;
    end

    mux_scan_capture #(.IN_LENGTH(16), .SEL_LENGTH(4), .SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_v[0]), .cont(cont), .stop(stop),
        .sel(sel_a), .mux_out(mux_a), .data_out(dout_a), .data_valid(dv_a),
        .data_ready(ready), .busy(busy_a)
    );

    mux_scan_capture #(.IN_LENGTH(16), .SEL_LENGTH(4), .SETTLE_CYCLES(0)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_v[1]), .cont(cont), .stop(stop),
        .sel(sel_b), .mux_out(mux_b), .data_out(dout_b), .data_valid(dv_b),
        .data_ready(ready), .busy(busy_b)
    );

    mux_scan_capture #(.IN_LENGTH(12), .SEL_LENGTH(4), .SETTLE_CYCLES(2)) dut_c (
        .clk(clk), .rstn(rstn), .start(start_v[2]), .cont(cont), .stop(stop),
        .sel(sel_c), .mux_out(mux_c), .data_out(dout_c), .data_valid(dv_c),
        .data_ready(ready), .busy(busy_c)
    );

    // Pulse start on instance w for one edge; caller sits just after an edge.
    task automatic kick(input int w, input logic c, input logic with_stop);
        cont       = c;
        stop       = with_stop;
        start_v[w] = 1'b1;
        @(posedge clk); #1;
        start_v    = '0;
        cont       = 1'b0;
        stop       = 1'b0;
    endtask

    // Follow one scan that began at the most recent edge.
    // The checks run cycle by cycle:
    //   - after edge T+m, sel = min(m/(S+1), N-1);
    //   - data_valid rises exactly at m = N*(S+1);
    //   - valid is then held for ready_delay cycles before the handshake.
    task automatic check_scan(input int w, input logic [15:0] word,
                              input int ready_delay, input int stop_at,
                              input logic expect_more, input logic poke_start);
        int n, s, len, exp_sel;
        logic [15:0] exp_w;
        n     = N_TAB[w];
        s     = S_TAB[w];
        len   = n * (s + 1);
        exp_w = word & ((n == 16) ? 16'hFFFF : 16'h0FFF);
        ready = (ready_delay == 0);
        for (int m = 0; m <= len; m++) begin
            exp_sel = (m / (s + 1) < n) ? m / (s + 1) : n - 1;
            total++;
            if (sel_o[w] !== 4'(exp_sel)) begin
                bad++;
                $display("FAIL scan_sel inst=%0d cyc=%0d got=%0d want=%0d", w, m, sel_o[w], exp_sel);
            end
            total++;
            if (dv[w] !== (m == len)) begin
                bad++;
                $display("FAIL scan_valid inst=%0d cyc=%0d got=%b want=%b", w, m, dv[w], (m == len));
            end
            total++;
            if (busy_o[w] !== 1'b1) begin
                bad++;
                $display("FAIL scan_busy inst=%0d cyc=%0d got=%b want=1", w, m, busy_o[w]);
            end
            if (m == stop_at) stop = 1'b1;
            if (m < len) begin
                @(posedge clk); #1;
                stop = 1'b0;
            end
        end
        stop = 1'b0;
        total++;
        if (dout[w] !== exp_w) begin
            bad++;
            $display("FAIL word inst=%0d got=%h want=%h", w, dout[w], exp_w);
        end
        for (int d = 0; d < ready_delay; d++) begin
            start_v[w] = poke_start && (d == 2);
            @(posedge clk); #1;
            start_v = '0;
            total++;
            if (dv[w] !== 1'b1 || dout[w] !== exp_w || sel_o[w] !== 4'(n - 1) || busy_o[w] !== 1'b1) begin
                bad++;
                $display("FAIL hold inst=%0d d=%0d valid=%b data=%h sel=%0d busy=%b want 1/%h/%0d/1",
                         w, d, dv[w], dout[w], sel_o[w], busy_o[w], exp_w, n - 1);
            end
        end
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        total++;
        if (dv[w] !== 1'b0 || busy_o[w] !== expect_more) begin
            bad++;
            $display("FAIL handshake inst=%0d valid=%b busy=%b want 0/%b", w, dv[w], busy_o[w], expect_more);
        end
        if (expect_more) begin
            total++;
            if (sel_o[w] !== 4'd0) begin
                bad++;
                $display("FAIL restart_sel inst=%0d got=%0d want=0", w, sel_o[w]);
            end
        end else begin
            @(posedge clk); #1;
            total++;
            if (busy_o[w] !== 1'b0 || dout[w] !== exp_w || dv[w] !== 1'b0) begin
                bad++;
                $display("FAIL idle_after inst=%0d busy=%b data=%h valid=%b want 0/%h/0",
                         w, busy_o[w], dout[w], dv[w], exp_w);
            end
        end
        $display("scan inst=%0d word=%h ready_delay=%0d more=%b", w, exp_w, ready_delay, expect_more);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int w = 0; w < 3; w++) begin
            total++;
            if (sel_o[w] !== 4'd0 || dout[w] !== 16'd0 || dv[w] !== 1'b0 || busy_o[w] !== 1'b0) begin
                bad++;
                $display("FAIL reset inst=%0d sel=%0d data=%h valid=%b busy=%b want all 0",
                         w, sel_o[w], dout[w], dv[w], busy_o[w]);
            end
        end
        $display("reset checked");
    endtask

    task automatic test_basic();
        in_w[0] = 16'hA5C3;
        kick(0, 1'b0, 1'b0);
        check_scan(0, 16'hA5C3, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        in_w[0] = 16'hA5C3;
        kick(0, 1'b0, 1'b0);
        check_scan(0, 16'hA5C3, 10, -1, 1'b0, 1'b1);
    endtask

    task automatic test_continuous();
        in_w[0] = 16'h00FF;
        kick(0, 1'b1, 1'b0);
        check_scan(0, 16'h00FF, 3, -1, 1'b1, 1'b0);
        in_w[0] = 16'hF00F;
        check_scan(0, 16'hF00F, 2, 7, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_scan();
        int i;
        in_w[0] = 16'h5A5A;
        kick(0, 1'b0, 1'b0);
        i = 0;
        while (i < 200 && sel_o[0] !== 4'd7) begin
            @(posedge clk); #1;
            i++;
        end
        total++;
        if (sel_o[0] !== 4'd7) begin
            bad++;
            $display("FAIL reach_sel7 got=%0d want=7", sel_o[0]);
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        total++;
        if (sel_o[0] !== 4'd0 || busy_o[0] !== 1'b0 || dv[0] !== 1'b0 || dout[0] !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset sel=%0d busy=%b valid=%b data=%h want 0/0/0/0000",
                     sel_o[0], busy_o[0], dv[0], dout[0]);
        end
        in_w[0] = 16'h1234;
        kick(0, 1'b0, 1'b0);
        check_scan(0, 16'h1234, 1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_settle();
        in_w[1] = 16'hFFFF;
        kick(1, 1'b0, 1'b0);
        check_scan(1, 16'hFFFF, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_short_length();
        in_w[2] = 16'h0ABC;
        kick(2, 1'b0, 1'b0);
        check_scan(2, 16'h0ABC, 2, -1, 1'b0, 1'b0);
        total++;
        if (sel_c_high !== 1'b0) begin
            bad++;
            $display("FAIL sel_range got=sel above 11 want=never above 11");
        end
    endtask

    task automatic test_random();
        int w;
        logic [15:0] word;
        for (int i = 0; i < 8; i++) begin
            w       = $urandom_range(0, 2);
            word    = 16'($urandom);
            in_w[w] = word;
            // Odd passes request continuous mode with stop in the same cycle,
            // which must still behave as a one-shot scan.
            kick(w, i[0], i[0]);
            check_scan(w, word, $urandom_range(0, 4), -1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        sel_c_high = 1'b0;
        rstn       = 1'b0;
        cont       = 1'b0;
        stop       = 1'b0;
        ready      = 1'b0;
        start_v    = '0;
        in_w[0]    = 16'h0;
        in_w[1]    = 16'h0;
        in_w[2]    = 16'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_continuous();
        test_reset_mid_scan();
        test_zero_settle();
        test_short_length();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
